// File: rtl/spi_pkg.sv
// Shared types for the SPI transmit scheduler.
// Word width, source id and scheduler state encoding.
package spi_pkg;

  localparam int SPI_WORD_W = 24;

  typedef logic [SPI_WORD_W-1:0] spi_word_t;
  typedef logic [2:0] src_id_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_CS_LOW,
    WAIT_CS_HIGH,
    GAP_ST
  } spi_sched_state_e;

endpackage

// File: rtl/spi_word_fifo.sv
// Small synchronous FIFO holding {src, word} entries.
// Push is dropped when full, pop is dropped when empty.
module spi_word_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = level == FULL_LVL;
  assign empty    = level == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Round-robin word scheduler feeding the 24-bit SPI engine.
// One frame per queued word, completion tracked on spi_cs_l.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter int W       = SPI_WORD_W,
  parameter int NREQ    = 2,
  parameter int DEPTH   = 4,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*W-1:0]      req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [W-1:0]           spi_data_out,
  output logic                   spi_start,
  input  logic                   spi_cs_l,
  output logic                   tx_done,
  output logic [2:0]             tx_src,
  output logic                   err_timeout,
  input  logic                   err_clr,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int EW   = 3 + W;
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 2);

  spi_sched_state_e state_q, state_d;

  src_id_t        rr_q;
  src_id_t        gnt_id;
  logic [W-1:0]   gnt_data;
  logic           gnt_hit;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [EW-1:0]  pop_ent;
  logic [CW-1:0]  cnt_q;
  logic           cnt_hit;
  logic           gap_done;
  logic           to_hit;
  logic [W-1:0]   data_q;
  src_id_t        src_q;

  // Two passes give the upward search from rr_q with wrap.
  always_comb begin
    gnt_hit  = 1'b0;
    gnt_id   = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_hit && i >= int'(rr_q) && req_valid[i]) begin
        gnt_hit  = 1'b1;
        gnt_id   = src_id_t'(i);
        gnt_data = req_data[i*W +: W];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_hit && i < int'(rr_q) && req_valid[i]) begin
        gnt_hit  = 1'b1;
        gnt_id   = src_id_t'(i);
        gnt_data = req_data[i*W +: W];
      end
    end
  end

  assign push = gnt_hit && !fifo_full && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = push && (gnt_id == src_id_t'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= (gnt_id == src_id_t'(NREQ - 1)) ? '0 : gnt_id + 3'd1;
    end
  end

  spi_word_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({gnt_id, gnt_data}),
    .pop       (pop),
    .pop_data  (pop_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign pop      = (state_q == IDLE) && !fifo_empty;
  assign cnt_hit  = cnt_q == CW'(TIMEOUT);
  assign gap_done = int'(cnt_q) + 1 >= GAP;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (!fifo_empty) state_d = LAUNCH;
      LAUNCH:       state_d = WAIT_CS_LOW;
      WAIT_CS_LOW: begin
        if (!spi_cs_l)    state_d = WAIT_CS_HIGH;
        else if (cnt_hit) state_d = GAP_ST;
      end
      WAIT_CS_HIGH: if (spi_cs_l || cnt_hit) state_d = GAP_ST;
      GAP_ST:       if (gap_done) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_start = 1'b0;
    tx_done   = 1'b0;
    tx_src    = '0;
    to_hit    = 1'b0;
    unique case (state_q)
      LAUNCH:       spi_start = 1'b1;
      WAIT_CS_LOW:  to_hit = spi_cs_l && cnt_hit;
      WAIT_CS_HIGH: begin
        tx_done = spi_cs_l;
        to_hit  = !spi_cs_l && cnt_hit;
      end
      default: ;
    endcase
    if (tx_done) tx_src = src_q;
  end

  // Every state change restarts the wait/gap counter.
  always_ff @(posedge clk) begin
    if (reset)                   cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (cnt_q != '1)        cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      src_q  <= '0;
    end else if (pop) begin
      data_q <= pop_ent[W-1:0];
      src_q  <= pop_ent[EW-1 -: 3];
    end
  end

  assign spi_data_out = data_q;

  always_ff @(posedge clk) begin
    if (reset)        err_timeout <= 1'b0;
    else if (to_hit)  err_timeout <= 1'b1;
    else if (err_clr) err_timeout <= 1'b0;
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Random bench for spi_tx_scheduler against a frame-timeline model.
// The engine's cs_l waveform is played from the model's frame plan.
module tb_spi_tx_scheduler;
  import spi_pkg::*;

  localparam int W       = SPI_WORD_W;
  localparam int NREQ    = 2;
  localparam int DEPTH   = 4;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 1023;
  localparam int NCYC    = 8000;
  localparam int GSPAN   = (GAP > 0) ? GAP : 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*W-1:0]      req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic [W-1:0]           spi_data_out;
  logic                   spi_start;
  logic                   spi_cs_l = 1'b1;
  logic                   tx_done;
  logic [2:0]             tx_src;
  logic                   err_timeout;
  logic                   err_clr = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  spi_tx_scheduler #(
    .W       (W),
    .NREQ    (NREQ),
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .spi_data_out (spi_data_out),
    .spi_start    (spi_start),
    .spi_cs_l     (spi_cs_l),
    .tx_done      (tx_done),
    .tx_src       (tx_src),
    .err_timeout  (err_timeout),
    .err_clr      (err_clr),
    .fifo_level   (fifo_level)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h",
               tag, cyc, got, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]   src;
    logic [W-1:0] data;
  } ent_t;

  ent_t         q[$];
  int           rr;
  bit           pend [NREQ];
  logic [W-1:0] pdata [NREQ];
  int           idle_from;
  bit           fr_act, fr_ok, fr_clr;
  int           fr_s, fr_lo_a, fr_lo_b, fr_end;
  logic [2:0]   fr_src;
  logic [W-1:0] last_data;
  bit           err_m;
  bit           to_a_done, to_b_done, did_rst;

  // Plan one frame: start cycle, cs_l low window, end cycle.
  task automatic plan_frame(input int c, input ent_t e);
    int s, lo;
    s         = c + 1;
    fr_act    = 1'b1;
    fr_s      = s;
    fr_src    = e.src;
    last_data = e.data;
    fr_clr    = 1'b0;
    lo        = s + 1 + int'($urandom_range(3));
    if (!to_a_done && c >= 2000) begin
      to_a_done = 1'b1;
      fr_ok   = 1'b0;
      fr_clr  = 1'b1;
      fr_lo_a = -1;
      fr_lo_b = -1;
      fr_end  = s + 1 + TIMEOUT;
    end else if (!to_b_done && c >= 4000) begin
      to_b_done = 1'b1;
      fr_ok   = 1'b0;
      fr_lo_a = lo;
      fr_lo_b = lo + 1 + TIMEOUT;
      fr_end  = fr_lo_b;
    end else begin
      fr_ok   = 1'b1;
      fr_lo_a = lo;
      fr_end  = lo + int'($urandom_range(28, 24));
      fr_lo_b = fr_end - 1;
    end
  endtask

  initial begin
    int         g;
    bit         rst_now;
    bit         exp_done;
    logic [NREQ-1:0] exp_rdy;
    ent_t       e;

    rr = 0; idle_from = 0; fr_act = 0; fr_ok = 0; fr_clr = 0;
    last_data = '0; err_m = 0;
    to_a_done = 0; to_b_done = 0; did_rst = 0;
    fr_s = -1; fr_lo_a = -1; fr_lo_b = -1; fr_end = -1; fr_src = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pdata[i] = '0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 10) begin
        pend[0]  = 1'b1;
        pdata[0] = 24'hA5A5A5;
      end
      rst_now = (c < 3);
      if (!did_rst && c > 6000 && fr_act && fr_ok &&
          c > fr_lo_a && c < fr_end && q.size() >= 2) begin
        rst_now = 1'b1;
        did_rst = 1'b1;
      end

      reset = rst_now;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]        = pend[i];
        req_data[i*W +: W]  = pdata[i];
      end
      spi_cs_l = !(fr_act && fr_lo_a >= 0 &&
                   c >= fr_lo_a && c <= fr_lo_b);
      err_clr = ($urandom_range(49) == 0);
      if (fr_act && fr_clr && c == fr_end) err_clr = 1'b1;

      #1;
      exp_rdy = '0;
      g = -1;
      if (q.size() < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && pend[(rr + k) % NREQ]) g = (rr + k) % NREQ;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_done = fr_act && fr_ok && c == fr_end;

      if (rst_now) begin
        chk("req_ready_rst", 32'(req_ready), 32'(0));
      end else begin
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("fifo_level", 32'(fifo_level), q.size());
        chk("spi_start", 32'(spi_start),
            32'(fr_act && c == fr_s));
        chk("spi_data_out", 32'(spi_data_out), 32'(last_data));
        chk("tx_done", 32'(tx_done), 32'(exp_done));
        chk("tx_src", 32'(tx_src),
            exp_done ? 32'(fr_src) : 32'(0));
        chk("err_timeout", 32'(err_timeout), 32'(err_m));
      end

      if (rst_now) begin
        q.delete();
        rr        = 0;
        fr_act    = 1'b0;
        idle_from = c + 1;
        last_data = '0;
        err_m     = 1'b0;
      end else begin
        if (fr_act && !fr_ok && c == fr_end) err_m = 1'b1;
        else if (err_clr)                    err_m = 1'b0;
        if (fr_act && c == fr_end) begin
          fr_act    = 1'b0;
          idle_from = c + 1 + GSPAN;
        end
        if (!fr_act && c >= idle_from && q.size() > 0) begin
          e = q.pop_front();
          plan_frame(c, e);
        end
        if (g >= 0) begin
          e.src  = 3'(g);
          e.data = pdata[g];
          q.push_back(e);
          pend[g] = 1'b0;
          rr      = (g + 1) % NREQ;
        end
      end

      // Fairness window: both producers always valid with fixed words.
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if (c >= 100 && c < 700) begin
            pend[i]  = 1'b1;
            pdata[i] = W'(i + 1);
          end else if (c >= 900 && $urandom_range(99) < 30) begin
            pend[i]  = 1'b1;
            pdata[i] = W'($urandom);
          end
        end
      end
    end

    cyc = NCYC;
    chk("mid_frame_reset_hit", 32'(did_rst), 32'(1));
    chk("timeouts_hit", 32'(to_a_done && to_b_done), 32'(1));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
